// File: rtl/blk_moment_accum.sv
// Block moment accumulator: sums w*f, f^2, g^2, w*g, w*f*g, f*g over BLK_N-pixel blocks.
// Latency: bundle registered on the edge accepting the last beat of a block, visible next cycle.
// Backpressure: in_ready drops only on a block's last beat while the previous bundle is unconsumed.
//
// Ports:
//   clk, rst (async, active-high), clr (sync block abort)
//   in_valid/in_ready + f, g (PIX_W, unsigned), w (weight mask)  : pixel beat stream
//   out_valid/out_ready + wf, f2sum, g2sum, wg, wfg, fg (SUM_W)   : block sum bundle
// Build option: define BLKMOM_SAT_EN to saturate sums at 2^SUM_W-1 instead of wrapping.
module blk_moment_accum #(
    parameter int PIX_W = 4,
    parameter int BLK_N = 64,
    parameter int SUM_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] f,
    input  logic [PIX_W-1:0] g,
    input  logic             w,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] wf,
    output logic [SUM_W-1:0] f2sum,
    output logic [SUM_W-1:0] g2sum,
    output logic [SUM_W-1:0] wg,
    output logic [SUM_W-1:0] wfg,
    output logic [SUM_W-1:0] fg
);

    localparam int CNT_W  = (BLK_N > 1) ? $clog2(BLK_N) : 1;
    localparam int PROD_W = 2 * PIX_W;
    // One bit of headroom above the wider operand so the sum never loses its carry.
    localparam int ADD_W  = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 1;
    localparam int NSUM   = 6;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLK_N - 1);
    localparam logic [ADD_W-1:0] SUM_MAX  = {{(ADD_W - SUM_W){1'b0}}, {SUM_W{1'b1}}};

    // Sum slot order: 0 wf, 1 f2sum, 2 g2sum, 3 wg, 4 wfg, 5 fg
    typedef enum logic {
        ACCUM = 1'b0,
        LAST  = 1'b1
    } state_e;

    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NSUM-1:0][SUM_W-1:0]   acc_q, acc_d;
    logic [NSUM-1:0][SUM_W-1:0]   sum_q, sum_d;
    logic                         out_valid_q, out_valid_d;
    logic [NSUM-1:0][PROD_W-1:0]  prod;
    logic [NSUM-1:0][SUM_W-1:0]   acc_nxt;
    logic [PROD_W-1:0]            fg_prod;
    state_e                       state;
    logic                         accept;

    // Block position alone determines the state; no separate state register needed.
    assign state    = (cnt_q == LAST_CNT) ? LAST : ACCUM;
    assign in_ready = (state != LAST) || !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !clr;

    function automatic logic [SUM_W-1:0] add_sum(input logic [SUM_W-1:0]  a,
                                                 input logic [PROD_W-1:0] p);
        logic [ADD_W-1:0] s;
        s = ADD_W'(a) + ADD_W'(p);
`ifdef BLKMOM_SAT_EN
        // Clamp; since products are non-negative a saturated sum stays pinned.
        if (s > SUM_MAX) begin
            s = SUM_MAX;
        end
`endif
        return s[SUM_W-1:0];
    endfunction

    always_comb begin
        fg_prod = PROD_W'(f) * PROD_W'(g);
        prod[0] = w ? PROD_W'(f) : '0;
        prod[1] = PROD_W'(f) * PROD_W'(f);
        prod[2] = PROD_W'(g) * PROD_W'(g);
        prod[3] = w ? PROD_W'(g) : '0;
        prod[4] = w ? fg_prod : '0;
        prod[5] = fg_prod;
        for (int i = 0; i < NSUM; i++) begin
            acc_nxt[i] = add_sum(acc_q[i], prod[i]);
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (clr) begin
            // Abort only the block in progress; a pending bundle is left intact.
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (state == LAST) begin
                // A fresh load overrides a same-cycle consume.
                cnt_d       = '0;
                acc_d       = '0;
                sum_d       = acc_nxt;
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = acc_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign wf        = sum_q[0];
    assign f2sum     = sum_q[1];
    assign g2sum     = sum_q[2];
    assign wg        = sum_q[3];
    assign wfg       = sum_q[4];
    assign fg        = sum_q[5];

endmodule

// File: tb/tb_blk_moment_accum.sv
module tb_blk_moment_accum;

    typedef struct packed {
        logic [13:0] wf;
        logic [13:0] f2;
        logic [13:0] g2;
        logic [13:0] wg;
        logic [13:0] wfg;
        logic [13:0] fg;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, in_ready, w, out_valid, out_ready;
    logic [3:0]  f, g;
    logic [13:0] wf, f2sum, g2sum, wg, wfg, fg;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [13:0] b_wf, b_f2sum, b_g2sum, b_wg, b_wfg, b_fg;

    int      pass_cnt = 0;
    int      total_cnt = 0;
    bundle_t exp_q[$];
    bundle_t mdl;
    bundle_t exp_b;
    int      mdl_n = 0;

    always #5 clk = ~clk;

    blk_moment_accum #(.PIX_W(4), .BLK_N(64), .SUM_W(14)) u_dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .f(f), .g(g), .w(w),
        .out_valid(out_valid), .out_ready(out_ready),
        .wf(wf), .f2sum(f2sum), .g2sum(g2sum), .wg(wg), .wfg(wfg), .fg(fg)
    );

    blk_moment_accum #(.PIX_W(4), .BLK_N(128), .SUM_W(14)) u_big (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .f(f), .g(g), .w(w),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .wf(b_wf), .f2sum(b_f2sum), .g2sum(b_g2sum), .wg(b_wg), .wfg(b_wfg), .fg(b_fg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] madd(input logic [13:0] a, input int unsigned p);
        logic [31:0] s;
        s = 32'(a) + p;
`ifdef BLKMOM_SAT_EN
        if (s > 32'd16383) s = 32'd16383;
`endif
        return s[13:0];
    endfunction

    // Reference model of one accepted beat on the BLK_N=64 instance.
    task automatic mdl_beat(input int unsigned fv, input int unsigned gv, input bit wv);
        mdl.wf  = madd(mdl.wf,  wv ? fv : 0);
        mdl.f2  = madd(mdl.f2,  fv * fv);
        mdl.g2  = madd(mdl.g2,  gv * gv);
        mdl.wg  = madd(mdl.wg,  wv ? gv : 0);
        mdl.wfg = madd(mdl.wfg, wv ? fv * gv : 0);
        mdl.fg  = madd(mdl.fg,  fv * gv);
        mdl_n++;
        if (mdl_n == 64) begin
            exp_q.push_back(mdl);
            mdl   = '0;
            mdl_n = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [3:0] fv, input logic [3:0] gv, input logic wv);
        int n;
        n = 0;
        in_valid = 1'b1;
        f = fv;
        g = gv;
        w = wv;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            return;
        end
        @(posedge clk);
        #1;
        mdl_beat(fv, gv, wv);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bundle", out_valid, 0);
            end else begin
                exp_b = exp_q.pop_front();
                check("sb_wf",  wf,    exp_b.wf);
                check("sb_f2",  f2sum, exp_b.f2);
                check("sb_g2",  g2sum, exp_b.g2);
                check("sb_wg",  wg,    exp_b.wg);
                check("sb_wfg", wfg,   exp_b.wfg);
                check("sb_fg",  fg,    exp_b.fg);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mdl = '0;
        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        f = '0;
        g = '0;
        w = 1'b0;
        b_in_valid = 1'b0;
        b_out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sums_zero", 32'(wf | f2sum | g2sum | wg | wfg | fg), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Full-scale block, free-flowing output
        for (int i = 0; i < 64; i++) send(4'd15, 4'd15, 1'b1);
        in_valid = 1'b0;
        check("max_out_valid", out_valid, 1);
        check("max_f2sum", f2sum, 14400);
        check("max_wfg", wfg, 14400);
        check("max_wf", wf, 960);
        check("max_wg", wg, 960);
        @(posedge clk);
        #1;
        check("max_valid_drop", out_valid, 0);

        // Weight mask off
        for (int i = 0; i < 64; i++) send(4'd3, 4'd5, 1'b0);
        in_valid = 1'b0;
        check("w0_g2sum", g2sum, 1600);
        check("w0_fg", fg, 960);
        check("w0_wfg", wfg, 0);
        @(posedge clk);
        #1;

        // Backpressure: block A held while block B stalls on its last beat
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(4'd1, 4'd1, 1'b1);
        for (int i = 0; i < 63; i++) send(4'd2, 4'd1, 1'b1);
        in_valid = 1'b1;
        f = 4'd2;
        g = 4'd1;
        w = 1'b1;
        @(negedge clk);
        check("bp_stall", in_ready, 0);
        repeat (3) @(negedge clk);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_wf", wf, 64);
        check("bp_hold_f2", f2sum, 64);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", in_ready, 1);
        @(posedge clk);
        #1;
        mdl_beat(2, 1, 1'b1);
        in_valid = 1'b0;
        check("bp_b_valid", out_valid, 1);
        check("bp_b_wf", wf, 128);
        check("bp_b_f2", f2sum, 256);
        @(posedge clk);
        #1;

        // clr at cnt=10 drops the presented beat and restarts the block
        for (int i = 0; i < 10; i++) send(4'd7, 4'd3, 1'b1);
        in_valid = 1'b1;
        f = 4'd9;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        mdl = '0;
        mdl_n = 0;
        for (int i = 0; i < 63; i++) send(4'd2, 4'd0, 1'b1);
        check("clr_no_early_valid", out_valid, 0);
        send(4'd2, 4'd0, 1'b1);
        in_valid = 1'b0;
        check("clr_valid", out_valid, 1);
        check("clr_wf", wf, 128);
        check("clr_f2", f2sum, 256);
        check("clr_fg", fg, 0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-block with a bundle pending
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) send(4'd1, 4'd2, 1'b1);
        for (int i = 0; i < 30; i++) send(4'd1, 4'd2, 1'b1);
        check("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_sums_zero", 32'(wf | f2sum | g2sum | wg | wfg | fg), 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        mdl = '0;
        mdl_n = 0;
        in_valid = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 64; i++) send(4'd15, 4'd0, 1'b1);
        in_valid = 1'b0;
        check("post_rst_f2", f2sum, 14400);
        check("post_rst_wf", wf, 960);
        check("post_rst_g2", g2sum, 0);
        @(posedge clk);
        #1;

        // BLK_N=128: overflow behaviour depends on the build option
        b_in_valid = 1'b1;
        f = 4'd15;
        g = 4'd15;
        w = 1'b1;
        for (int i = 0; i < 128; i++) begin
            n = 0;
            @(negedge clk);
            while (!b_in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (i == 127) check("big_no_early_valid", b_out_valid, 0);
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;
        check("big_valid", b_out_valid, 1);
`ifdef BLKMOM_SAT_EN
        check("big_f2sum", b_f2sum, 16383);
        check("big_fg", b_fg, 16383);
`else
        check("big_f2sum", b_f2sum, 12416);
        check("big_fg", b_fg, 12416);
`endif
        check("big_wf", b_wf, 1920);
        check("big_wg", b_wg, 1920);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
